// File: rtl/dequant_pkg.sv
// dequant_pkg: widths, FSM state and width check for dequant_stream (DEQUANT_SHIFT_EN adds a rounding shift)
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package dequant_pkg;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int ACC_WIDTH = `ACC_WIDTH;
  localparam int SCALE_WIDTH = 16;
  localparam int LANES = 4;
  localparam int PROD_WIDTH = DATA_WIDTH + 1 + SCALE_WIDTH;
  localparam int CNT_WIDTH = $clog2(LANES);
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic logic width_ok(input int acc, input int data, input int scl, input int lanes);
    return acc >= data + 1 + scl && lanes >= 2;
  endfunction
endpackage

// File: rtl/dequant_lane.sv
// dequant_lane: (x - zp) * scale with optional round-half-up shift (DEQUANT_SHIFT_EN), sign-extended to ACC_WIDTH
module dequant_lane
  import dequant_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]  x,
  input  logic [DATA_WIDTH-1:0]  zp,
  input  logic [SCALE_WIDTH-1:0] scale,
`ifdef DEQUANT_SHIFT_EN
  input  logic [4:0]             shift,
`endif
  output logic [ACC_WIDTH-1:0]   y
);
  logic signed [DATA_WIDTH:0] d;
  logic signed [PROD_WIDTH-1:0] p;
  assign d = (DATA_WIDTH+1)'($signed(x)) - (DATA_WIDTH+1)'($signed(zp));
  assign p = PROD_WIDTH'(d) * PROD_WIDTH'($signed(scale));
`ifdef DEQUANT_SHIFT_EN
  logic signed [PROD_WIDTH:0] rnd, r;
  assign rnd = shift == 5'd0 ? '0 : (PROD_WIDTH+1)'(1) << (shift - 5'd1);
  assign r = (PROD_WIDTH+1)'(p) + rnd;
  assign y = ACC_WIDTH'(r >>> shift);
`else
  assign y = ACC_WIDTH'(p);
`endif
endmodule

// File: rtl/dequant_stream.sv
// dequant_stream: serialises LANES quantized lanes into dequantized ACC_WIDTH values (DEQUANT_SHIFT_EN adds shift port)
module dequant_stream
  import dequant_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   s_data,
  input  logic                          s_last,
  input  logic [DATA_WIDTH-1:0]         zero_point,
  input  logic [SCALE_WIDTH-1:0]        scale,
`ifdef DEQUANT_SHIFT_EN
  input  logic [4:0]                    shift,
`endif
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ACC_WIDTH-1:0]          m_data,
  output logic                          m_last
);
  if (!width_ok(ACC_WIDTH, DATA_WIDTH, SCALE_WIDTH, LANES)) begin : g_bad_width
    $error("dequant_stream: ACC_WIDTH too narrow or LANES < 2");
  end
  state_t state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [LANES*DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] zp_r;
  logic [SCALE_WIDTH-1:0] scale_r;
  logic last_r, fin;
`ifdef DEQUANT_SHIFT_EN
  logic [4:0] shift_r;
`endif
  assign fin = cnt == CNT_WIDTH'(LANES - 1);
  assign m_valid = state == EMIT;
  assign m_last = m_valid && fin && last_r;
  // final-lane handshake and reload share a cycle so consecutive words have no bubble
  assign s_ready = !rst && (state == IDLE || (fin && m_ready));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
      zp_r <= '0;
      scale_r <= '0;
      last_r <= 1'b0;
`ifdef DEQUANT_SHIFT_EN
      shift_r <= '0;
`endif
    end else if (s_valid && s_ready) begin
      state <= EMIT;
      cnt <= '0;
      word <= s_data;
      zp_r <= zero_point;
      scale_r <= scale;
      last_r <= s_last;
`ifdef DEQUANT_SHIFT_EN
      shift_r <= shift;
`endif
    end else if (state == EMIT && m_ready) begin
      if (fin) state <= IDLE;
      else cnt <= cnt + CNT_WIDTH'(1);
    end
  end
  dequant_lane u_lane (
    .x     (word[DATA_WIDTH*cnt +: DATA_WIDTH]),
    .zp    (zp_r),
    .scale (scale_r),
`ifdef DEQUANT_SHIFT_EN
    .shift (shift_r),
`endif
    .y     (m_data)
  );
endmodule

// File: tb/tb_dequant_stream.sv
// tb_dequant_stream: directed self-checking bench for dequant_stream
module tb_dequant_stream;
  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0] s_data, m_data;
  logic [7:0] zero_point;
  logic [15:0] scale;
  logic [4:0] shift;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  dequant_stream dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .zero_point(zero_point), .scale(scale),
`ifdef DEQUANT_SHIFT_EN
    .shift(shift),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(want));
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int e);
    return {8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic send(input logic [31:0] d, input int z, input int sc, input logic l, input int sh);
    s_data = d; zero_point = 8'(z); scale = 16'(sc); s_last = l; shift = 5'(sh); s_valid = 1'b1;
    #1;
    for (int k = 0; k < 16 && !s_ready; k++) begin @(negedge clk); #1; end
    chk("accept", {31'd0, s_ready}, 1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && m_valid; k++) begin @(negedge clk); #1; end
    chk("drain", {31'd0, m_valid}, 0);
  endtask

  int basic_want[4] = '{26, -250, 260, 6};
  int b2b_want[12] = '{3, 6, 9, 12, -3, -6, -9, -12, 12, 15, 18, 21};
  logic bp_mr[7] = '{1, 0, 0, 1, 1, 0, 1};
  int bp_want[7] = '{20, 30, 30, 30, 40, 50, 50};
  logic bp_last[7] = '{0, 0, 0, 0, 0, 1, 1};
  logic bp_sr[7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    zero_point = '0; scale = '0; shift = '0; m_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, s_ready}, 1);

    send(pk(10, -128, 127, 0), -3, 2, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("basic_data", m_data, basic_want[i]);
      chk("basic_valid", {31'd0, m_valid}, 1);
      chk("basic_last", {31'd0, m_last}, (i == 3) ? 1 : 0);
      chk("basic_s_ready", {31'd0, s_ready}, (i == 3) ? 1 : 0);
      @(negedge clk); #1;
    end
    chk("basic_idle", {31'd0, m_valid}, 0);

    send(pk(1, 2, 3, 4), 0, 3, 1'b0, 0);
    s_data = pk(-1, -2, -3, -4); s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_data", m_data, b2b_want[i]);
      chk("b2b_valid", {31'd0, m_valid}, 1);
      chk("b2b_s_ready", {31'd0, s_ready}, (i % 4 == 3) ? 1 : 0);
      chk("b2b_last", {31'd0, m_last}, (i == 11) ? 1 : 0);
      if (i == 4) begin s_data = pk(5, 6, 7, 8); zero_point = 8'd1; s_last = 1'b1; end
      if (i == 8) s_valid = 1'b0;
      @(negedge clk); #1;
    end
    chk("b2b_idle", {31'd0, m_valid}, 0);

    send(pk(20, 30, 40, 50), 0, 1, 1'b1, 0);
    for (int i = 0; i < 7; i++) begin
      m_ready = bp_mr[i];
      #1;
      chk("bp_data", m_data, bp_want[i]);
      chk("bp_last", {31'd0, m_last}, {31'd0, bp_last[i]});
      chk("bp_s_ready", {31'd0, s_ready}, {31'd0, bp_sr[i]});
      @(negedge clk); #1;
    end
    m_ready = 1'b1;
    chk("bp_idle", {31'd0, m_valid}, 0);

    send(pk(-128, 0, 0, 0), 127, -32768, 1'b0, 0);
    chk("ext_pos", m_data, 8355840);
    drain();
    send(pk(127, 0, 0, 0), -128, -32768, 1'b0, 0);
    chk("ext_neg", m_data, -8355840);
    drain();

    send(pk(9, 8, 7, 6), 0, 1, 1'b0, 0);
    chk("rst_lane0", m_data, 9);
    @(negedge clk); #1;
    chk("rst_lane1", m_data, 8);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_valid", {31'd0, m_valid}, 0);
    chk("mid_rst_data", m_data, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, s_ready}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("no_stale_lane", {31'd0, m_valid}, 0);
    end
    send(pk(11, 21, 31, 41), 1, -1, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fresh_data", m_data, -10 * (i + 1));
      chk("fresh_last", {31'd0, m_last}, (i == 3) ? 1 : 0);
      @(negedge clk); #1;
    end
    chk("fresh_idle", {31'd0, m_valid}, 0);

`ifdef DEQUANT_SHIFT_EN
    send(pk(10, -128, 0, 0), -3, 2, 1'b0, 2);
    chk("shift_pos", m_data, 7);
    @(negedge clk); #1;
    chk("shift_neg", m_data, -62);
    drain();
    send(pk(10, -128, 0, 0), -3, 2, 1'b0, 0);
    chk("shift_zero", m_data, 26);
    drain();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
